// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types for the multiplier arbiter: arbiter state
//                encoding, operand width and the requester tag carried
//                alongside each multiply through the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_OP_W = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } mult_tag_t;

endpackage
`default_nettype wire

// File: rtl/mult_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mult_tag_pipe
//  Description : DEPTH-deep shift register of requester tags. It runs in
//                lock-step with the external multiplier, so the tag leaving
//                the last stage identifies the owner of the current result.
//  Ports       : clk, rst   - clock, synchronous active-high clear
//                tag_in     - tag loaded into stage 0 every cycle
//                tag_out    - tag in the last stage
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_tag_pipe
    import mult_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  mult_tag_t tag_in,
    output mult_tag_t tag_out
);

    mult_tag_t stage_q [DEPTH];
    mult_tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Clearing on reset drops every in-flight tag, so results of ops issued
    // before reset are never routed to a requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mult_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arb
//  Description : Two-requester arbiter for a shared fixed-latency 16x16
//                multiplier. Grants one operand pair per cycle, tags each op
//                with its requester, routes results back by tag, and offers a
//                drain handshake that quiesces the multiplier.
//  Config      : MULT_ARB_FIXED_PRIO_EN - when defined, req0 always wins
//                contention; otherwise contention is round-robin.
//  Ports       : clk, rst                     - clock, sync active-high reset
//                reqN_valid/a/b, reqN_ready   - requester operand handshake
//                mult_en/a/b, mult_rdy        - multiplier issue interface
//                mult_result                  - multiplier output
//                resp0_valid, resp1_valid     - result ownership pulses
//                resp_data                    - routed result
//                drain, drain_done            - quiesce handshake
//                busy                         - ops in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_arb
    import mult_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [MULT_OP_W-1:0] req0_a,
    input  logic [MULT_OP_W-1:0] req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [MULT_OP_W-1:0] req1_a,
    input  logic [MULT_OP_W-1:0] req1_b,
    output logic                 req1_ready,
    output logic                 mult_en,
    output logic [MULT_OP_W-1:0] mult_a,
    output logic [MULT_OP_W-1:0] mult_b,
    input  logic                 mult_rdy,
    input  logic [WIDTH-1:0]     mult_result,
    output logic                 resp0_valid,
    output logic                 resp1_valid,
    output logic [WIDTH-1:0]     resp_data,
    input  logic                 drain,
    output logic                 drain_done,
    output logic                 busy
);

    localparam int              CNT_W   = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             grant_ok;
    logic             grant_id;
    logic             contend_id;
    logic             resp_hit;
    mult_tag_t        tag_in;
    mult_tag_t        tag_out;

    // ------------------------------------------------------------------
    // Contention winner
    // ------------------------------------------------------------------
`ifdef MULT_ARB_FIXED_PRIO_EN
    assign contend_id = 1'b0;
`else
    logic last_grant_q, last_grant_d;

    assign contend_id   = ~last_grant_q;
    // Only an actual issue moves the round-robin pointer.
    assign last_grant_d = mult_en ? grant_id : last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;   // req0 wins the first contention
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Combinational grant; gated by rst so all outputs read 0 in reset
    // ------------------------------------------------------------------
    always_comb begin
        grant_ok = !rst && (state_q == RUN) && mult_rdy;
        grant_id = 1'b0;
        mult_en  = 1'b0;
        if (grant_ok) begin
            if (req0_valid && req1_valid) begin
                grant_id = contend_id;
            end else begin
                grant_id = req1_valid;
            end
            mult_en = req0_valid || req1_valid;
        end
        req0_ready = mult_en && !grant_id;
        req1_ready = mult_en &&  grant_id;
        mult_a     = '0;
        mult_b     = '0;
        if (mult_en) begin
            mult_a = grant_id ? req1_a : req0_a;
            mult_b = grant_id ? req1_b : req0_b;
        end
        tag_in.valid = mult_en;
        tag_in.id    = grant_id;
    end

    mult_tag_pipe #(
        .DEPTH   (LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // ------------------------------------------------------------------
    // Response routing: pass-through of the multiplier output
    // ------------------------------------------------------------------
    always_comb begin
        resp_hit    = !rst && tag_out.valid;
        resp0_valid = resp_hit && !tag_out.id;
        resp1_valid = resp_hit &&  tag_out.id;
        resp_data   = resp_hit ? mult_result : '0;
    end

    // ------------------------------------------------------------------
    // In-flight counter and FSM
    // ------------------------------------------------------------------
    always_comb begin
        case ({mult_en, resp_hit})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // DRAIN looks at the post-update count so HALT is entered on the same
    // edge that retires the last in-flight result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain)          state_d = DRAIN;
            DRAIN:   if (count_d == '0)  state_d = HALT;
            HALT:    if (!drain)         state_d = RUN;
            default:                     state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign drain_done = (state_q == HALT);
    assign busy       = (count_q != '0);

endmodule
`default_nettype wire

// File: doc/mult_arb.md
# mult_arb

Two-requester arbiter and sequencer for the shared fixed-latency 16x16 multiplier pipeline. It grants one operand pair per cycle to the multiplier and carries a requester tag alongside each operation. When a result emerges, the tag routes it back to the requester that issued it. It also provides a drain handshake, so the write/read memory sequencer can quiesce the multiplier before a block read.

## Interface
Parameters:
- LATENCY, 4, cycles from issue edge to result valid at `mult_result`; legal range 1-15
- WIDTH, 32, result width

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a, req0_b  in  16  requester 0 operands
- req0_ready  out  1  requester 0 granted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same meaning for requester 1
- mult_en  out  1  issue to multiplier
- mult_a, mult_b  out  16  operands of granted requester, zero when idle
- mult_rdy  in  1  multiplier accepts issue
- mult_result  in  WIDTH  multiplier output, valid LATENCY cycles after issue
- resp0_valid, resp1_valid  out  1  result belongs to requester 0 / 1
- resp_data  out  WIDTH  result, zero when neither response valid
- drain  in  1  request quiesce
- drain_done  out  1  no ops in flight and no grants
- busy  out  1  in-flight count nonzero

## Operation
- States (`arb_state_t`): RUN, DRAIN, HALT. Reset state is RUN.
- Grants occur only in RUN with mult_rdy=1.
  - One requester valid: grant it.
  - Both valid: grant the requester not granted last.
  - `last_grant` resets to 1, so req0 wins the first contention.
  - `last_grant` updates only on an actual grant.
- Grant signals are combinational: `reqN_ready`, `mult_en`, `mult_a`, `mult_b`.
  - A handshake completes on a clock edge where valid and ready are both high.
  - Requesters hold operands while valid and not ready.
- Tag pipeline: LATENCY stages of {valid, id}, shifted every cycle. Stage 0 loads {mult_en, granted id}.
- At the last stage, `respN_valid` = tag valid and id==N, and `resp_data` = `mult_result` (pass-through, zero otherwise).
  - Responses are single-cycle pulses with no backpressure.
- In-flight counter, width clog2(LATENCY+1):
  - +1 on issue, -1 on response, unchanged when both occur in the same cycle.
  - `busy` = counter != 0.
- State transitions:
  - RUN -> DRAIN when drain=1.
  - DRAIN -> HALT when counter==0; no grants in DRAIN.
  - HALT -> RUN when drain=0.
  - If drain drops during DRAIN, the block still completes the drain and passes through HALT for one cycle.
- `drain_done` = 1 only in HALT.
- While mult_rdy=0, no grant is made and the tag pipeline still shifts.
- Reset mid-operation discards all in-flight tags: no response is ever produced for ops issued before reset.

## Timing
- Reset values:
  - All outputs 0.
  - Counter 0.
  - Tag pipeline cleared.
  - State RUN.
- Issue latency is 0 cycles: ready is asserted in the same cycle as valid when granted.
- A response for an op issued at edge T is valid in the cycle after edge T+LATENCY-1; it is visible from edge T+LATENCY-1 to T+LATENCY.
  - With LATENCY=4 this matches the multiplier's 4-register path.
- Throughput is one op per cycle, shared between requesters.
- Drain with an empty pipeline: drain rising at edge E puts the state in DRAIN after E and in HALT after E+1. `drain_done` is high from E+1.

## Configuration
- MULT_ARB_FIXED_PRIO_EN defined: req0 always wins contention, `last_grant` is not used, and req1 may starve.
- Undefined (default): round-robin as described in Operation.

## Structure
- Package `mult_pkg` holds:
  - `arb_state_t` (RUN, DRAIN, HALT)
  - localparam `MULT_OP_W = 16`
  - typedef `mult_tag_t` {logic valid; logic id;}
- One sub-module, `mult_tag_pipe`: a LATENCY-deep shift register of `mult_tag_t` with synchronous clear. The top level holds the arbitration, the FSM and the counter.

## Test plan
- req0 a=3 b=5 alone, mult_rdy=1: req0_ready=1 the same cycle, mult_a=3, mult_b=5; resp0_valid=1 four cycles later with resp_data=15; resp1_valid stays 0.
- Both valid for 6 cycles: grant sequence 0,1,0,1,0,1, and responses arrive in the same order 4 cycles later.
- mult_rdy=0 for 3 cycles with req1 valid: req1_ready=0 and mult_en=0; grant occurs in the cycle mult_rdy returns to 1.
- Issue 3 ops, then assert drain: no further grants, drain_done rises the cycle after the third response, and RUN resumes one cycle after drain drops.
- Issue 2 ops, then pulse rst: no resp0_valid or resp1_valid ever follows, busy=0, and the first contention after reset grants req0.
- Build with MULT_ARB_FIXED_PRIO_EN and both requesters valid for 5 cycles: req0 is granted every cycle and req1_ready stays 0.
